pio_gpio_param: RTL and testbench

PIO_GPIO_PARAM -- requirements
Module: pio_gpio_param

---
 rtl/pio_gpio_param_if.sv | 29 ++
 rtl/pio_gpio_param.sv | 189 ++++++++++++++++++
 tb/tb_pio_gpio_param.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_gpio_param_if.sv
// ---------------------------------------------------------------------------
// pio_gpio_param_if
// Register-bus bundle for the parallel I/O block.
//   address    [2:0]  register word select
//   chipselect        slave select
//   write_n           active-low write strobe
//   read_n            active-low read strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (driven by the slave)
// Modports: master (bus initiator), slave (the GPIO block).
// ---------------------------------------------------------------------------
interface pio_gpio_param_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_gpio_param.sv
// ---------------------------------------------------------------------------
// pio_gpio_param
// Parameterised parallel I/O port with direction control, set/clear output
// helpers and optional edge capture with a level interrupt.
//
// Parameters:
//   DATA_WIDTH   port/register width (1..32)
//   RESET_VALUE  reset value of the output data register
//   EDGE_TYPE    edge-capture sense: 0 rising, 1 falling, 2 any
//
// Ports:
//   clk       clock, all state changes on its rising edge
//   reset_n   asynchronous active-low reset
//   bus       register bus (pio_gpio_param_if.slave)
//   in_port   asynchronous external inputs
//   out_port  output data register
//   oe_port   per-bit output enable (direction register)
//   irq       level interrupt, OR of (EDGECAP & IRQMASK)
//
// Register map: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLR,
// 6-7 read 0 / ignore writes.
//
// Build option: define PIO_GPIO_EDGE_IRQ_EN to include the edge-capture,
// IRQMASK and irq logic. Without it IRQMASK/EDGECAP read 0, ignore writes,
// irq is tied low and the third input flop is not built.
// ---------------------------------------------------------------------------
module pio_gpio_param #(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_gpio_param_if.slave       bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam logic [DATA_WIDTH-1:0] RESET_DATA = RESET_VALUE[DATA_WIDTH-1:0];

  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  unused_wdata;

  logic [DATA_WIDTH-1:0] sync1_reg;
  logic [DATA_WIDTH-1:0] sync2_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic [DATA_WIDTH-1:0] data_out_next;
  logic [DATA_WIDTH-1:0] dir_reg;
  logic [DATA_WIDTH-1:0] dir_next;
  logic [DATA_WIDTH-1:0] data_rd;
  logic [DATA_WIDTH-1:0] irqmask_rd;
  logic [DATA_WIDTH-1:0] edgecap_rd;
  logic [31:0]           read_word;
  logic [31:0]           readdata_reg;
  logic [31:0]           readdata_next;

  assign write_en = bus.chipselect & ~bus.write_n;
  assign read_en  = bus.chipselect & ~bus.read_n;

  // Only the low DATA_WIDTH bits of writedata are meaningful.
  assign wdata        = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  // DATA reads back the driven value on output bits, the synchronised pin
  // value on input bits.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_rd
      assign data_rd[gi] = dir_reg[gi] ? data_out_reg[gi] : sync2_reg[gi];
    end
  endgenerate

  always_comb begin
    data_out_next = data_out_reg;
    dir_next      = dir_reg;
    if (write_en) begin
      case (bus.address)
        ADDR_DATA:   data_out_next = wdata;
        ADDR_DIR:    dir_next      = wdata;
        ADDR_OUTSET: data_out_next = data_out_reg | wdata;
        ADDR_OUTCLR: data_out_next = data_out_reg & ~wdata;
        default:     ;
      endcase
    end
  end

  // The read mux looks at current register contents, so a read that
  // coincides with a write to the same address returns the old value.
  always_comb begin
    read_word = '0;
    case (bus.address)
      ADDR_DATA:    read_word[DATA_WIDTH-1:0] = data_rd;
      ADDR_DIR:     read_word[DATA_WIDTH-1:0] = dir_reg;
      ADDR_IRQMASK: read_word[DATA_WIDTH-1:0] = irqmask_rd;
      ADDR_EDGECAP: read_word[DATA_WIDTH-1:0] = edgecap_rd;
      default:      read_word = '0;
    endcase
    readdata_next = read_en ? read_word : readdata_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      data_out_reg <= RESET_DATA;
      dir_reg      <= '0;
      readdata_reg <= '0;
    end else begin
      sync1_reg    <= in_port;
      sync2_reg    <= sync1_reg;
      data_out_reg <= data_out_next;
      dir_reg      <= dir_next;
      readdata_reg <= readdata_next;
    end
  end

`ifdef PIO_GPIO_EDGE_IRQ_EN
  logic [DATA_WIDTH-1:0] sync3_reg;
  logic [DATA_WIDTH-1:0] irqmask_reg;
  logic [DATA_WIDTH-1:0] irqmask_next;
  logic [DATA_WIDTH-1:0] edgecap_reg;
  logic [DATA_WIDTH-1:0] edgecap_next;
  logic [DATA_WIDTH-1:0] edge_det;

  // sync3 holds the previous synchronised value; all flops reset to 0, so a
  // falling-edge build cannot see a spurious edge right after reset.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = sync2_reg & ~sync3_reg;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~sync2_reg & sync3_reg;
    end else begin : g_any
      assign edge_det = sync2_reg ^ sync3_reg;
    end
  endgenerate

  // Write-1-to-clear is applied first, then new edges are ORed in, so an
  // edge arriving in the same cycle as a clear keeps the bit set.
  always_comb begin
    irqmask_next = irqmask_reg;
    edgecap_next = edgecap_reg;
    if (write_en && (bus.address == ADDR_IRQMASK)) begin
      irqmask_next = wdata;
    end
    if (write_en && (bus.address == ADDR_EDGECAP)) begin
      edgecap_next = edgecap_reg & ~wdata;
    end
    edgecap_next = edgecap_next | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync3_reg   <= '0;
      irqmask_reg <= '0;
      edgecap_reg <= '0;
    end else begin
      sync3_reg   <= sync2_reg;
      irqmask_reg <= irqmask_next;
      edgecap_reg <= edgecap_next;
    end
  end

  assign irqmask_rd = irqmask_reg;
  assign edgecap_rd = edgecap_reg;
  assign irq        = |(edgecap_reg & irqmask_reg);
`else
  logic unused_edge_cfg;

  assign unused_edge_cfg = (EDGE_TYPE > 2);
  assign irqmask_rd      = '0;
  assign edgecap_rd      = '0;
  assign irq             = 1'b0;
`endif

  assign out_port     = data_out_reg;
  assign oe_port      = dir_reg;
  assign bus.readdata = readdata_reg;

endmodule

// File: tb/tb_pio_gpio_param.sv
// ---------------------------------------------------------------------------
// tb_pio_gpio_param
// Scoreboard bench for pio_gpio_param (DATA_WIDTH=8, RESET_VALUE=0xA5,
// EDGE_TYPE=0). Stimulus pushes expected values into a queue; a monitor on
// the falling clock edge pops and compares whenever a read completes or a
// pin sample is requested. Edge/irq expectations follow the
// PIO_GPIO_EDGE_IRQ_EN build option.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pio_gpio_param;

  localparam int DW = 8;

`ifdef PIO_GPIO_EDGE_IRQ_EN
  localparam logic [31:0] EN = 32'h1;
`else
  localparam logic [31:0] EN = 32'h0;
`endif

  // kind: 0 readdata after a read, 1 out_port, 2 oe_port, 3 irq, 4 readdata pin
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } item_t;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] in_port;
  logic [DW-1:0] out_port;
  logic [DW-1:0] oe_port;
  logic          irq;
  logic          rd_valid;
  logic          pin_strobe;

  item_t sb[$];
  item_t mon_item;
  logic [31:0] mon_act;
  int checks;
  int errors;

  pio_gpio_param_if bus ();

  pio_gpio_param #(
    .DATA_WIDTH (DW),
    .RESET_VALUE(32'h0000_00A5),
    .EDGE_TYPE  (0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .out_port(out_port),
    .oe_port (oe_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A read issued on one edge presents readdata after that same edge.
  always @(posedge clk) rd_valid <= bus.chipselect && !bus.read_n;

  always @(negedge clk) begin
    if (rd_valid || pin_strobe) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: scoreboard empty, readdata=%h out_port=%h irq=%b",
                 bus.readdata, out_port, irq);
      end else begin
        mon_item = sb.pop_front();
        case (mon_item.kind)
          1:       mon_act = {24'h0, out_port};
          2:       mon_act = {24'h0, oe_port};
          3:       mon_act = {31'h0, irq};
          default: mon_act = bus.readdata;
        endcase
        if (mon_act !== mon_item.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", mon_item.name, mon_act, mon_item.exp);
        end else begin
          $display("ok   %s: got %h", mon_item.name, mon_act);
        end
      end
    end
  end

  task automatic push_exp(input string n, input int k, input logic [31:0] e);
    item_t it;
    it.name = n;
    it.kind = k;
    it.exp  = e;
    sb.push_back(it);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input string n, input logic [2:0] a, input logic [31:0] e);
    push_exp(n, 0, e);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    @(posedge clk); #1;
  endtask

  // Read and write the same address on the same edge.
  task automatic bus_rw(input string n, input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] e);
    push_exp(n, 0, e);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.read_n     = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pin_check(input string n, input int k, input logic [31:0] e);
    push_exp(n, k, e);
    pin_strobe = 1'b1;
    @(posedge clk); #1;
    pin_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, queue holds %0d items, required 0", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    in_port        = '0;
    pin_strobe     = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;

    @(posedge clk); #1;
    pin_check("rst_readdata", 4, 32'h0);
    pin_check("rst_out_port", 1, 32'hA5);
    pin_check("rst_oe_port",  2, 32'h0);
    pin_check("rst_irq",      3, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Direction and reset value readback
    bus_write(3'd1, 32'hFF);
    pin_check("oe_after_dir", 2, 32'hFF);
    bus_read("data_reset_value", 3'd0, 32'hA5);
    bus_read("dir_readback",     3'd1, 32'hFF);

    // DATA / OUTSET / OUTCLR
    bus_write(3'd0, 32'h0F);
    bus_write(3'd4, 32'hF0);
    pin_check("out_after_set", 1, 32'hFF);
    bus_write(3'd5, 32'h03);
    pin_check("out_after_clr", 1, 32'hFC);
    bus_read("outset_reads_0", 3'd4, 32'h0);
    bus_read("outclr_reads_0", 3'd5, 32'h0);
    bus_read("data_after_clr", 3'd0, 32'hFC);

    // Upper writedata bits ignored
    bus_write(3'd0, 32'hABCD_1234);
    pin_check("out_wide_write", 1, 32'h34);
    bus_read("data_wide_write", 3'd0, 32'h34);

    // Unmapped addresses
    bus_write(3'd6, 32'h77);
    bus_write(3'd7, 32'h77);
    bus_read("addr6_reads_0", 3'd6, 32'h0);
    bus_read("addr7_reads_0", 3'd7, 32'h0);
    bus_read("data_unchanged", 3'd0, 32'h34);

    // Mixed direction: high nibble from pins, low nibble from data_out
    bus_write(3'd1, 32'h0F);
    in_port = 8'hA5;
    repeat (3) begin @(posedge clk); #1; end
    bus_read("data_mixed_dir", 3'd0, 32'hA4);
    bus_rw("rw_pre_write", 3'd0, 32'h55, 32'hA4);
    bus_read("data_post_write", 3'd0, 32'hA5);
    pin_check("out_post_rw", 1, 32'h55);
    bus_read("irqmask_reset", 3'd2, 32'h0);

    // Edge capture setup: settle inputs low, clear stale captures
    bus_write(3'd1, 32'h00);
    in_port = 8'h00;
    repeat (4) begin @(posedge clk); #1; end
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h01);
    bus_read("irqmask_readback", 3'd2, EN);
    bus_read("edgecap_cleared",  3'd3, 32'h0);
    pin_check("irq_idle", 3, 32'h0);

    // Rising edge on bit0: irq appears on the third edge after the change
    in_port = 8'h01;
    pin_check("irq_lat0", 3, 32'h0);
    pin_check("irq_lat1", 3, 32'h0);
    pin_check("irq_lat2", 3, 32'h0);
    pin_check("irq_edge", 3, EN);
    bus_read("edgecap_bit0", 3'd3, EN);
    bus_write(3'd3, 32'h01);
    pin_check("irq_after_clear", 3, 32'h0);

    // New edge lands on the same edge as a clear of the same bit
    in_port = 8'h00;
    repeat (4) begin @(posedge clk); #1; end
    in_port = 8'h01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_write(3'd3, 32'h01);
    pin_check("irq_edge_vs_clear", 3, EN);
    bus_read("edgecap_edge_vs_clear", 3'd3, EN);

    // Asynchronous reset in mid-operation
    bus_write(3'd1, 32'h0F);
    bus_write(3'd0, 32'hFF);
    pin_check("out_before_reset", 1, 32'hFF);
    reset_n = 1'b0;
    in_port = 8'h00;
    pin_check("out_async_reset", 1, 32'hA5);
    pin_check("irq_async_reset", 3, 32'h0);
    pin_check("oe_async_reset",  2, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read("edgecap_after_reset", 3'd3, 32'h0);
    bus_read("irqmask_after_reset", 3'd2, 32'h0);
    bus_read("dir_after_reset",     3'd1, 32'h0);

    repeat (3) begin @(posedge clk); #1; end
    while (sb.size() != 0) begin
      mon_item = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never observed, expected %h", mon_item.name, mon_item.exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
